encode_deframer: RTL and testbench

- Downstream of the comparator encoder stage.
- Each cycle the encoder asserts start, it produces one comparison bit (data >= delay). This block samples that bit stream, packs it into WORD_W-bit words (first bit lands in MSB) and counts the ones per word.
- Completed words are buffered in a small first-word-fall-through FIFO, which drains through a valid/ready handshake to the next consumer (UART/LED display logic).

---
 rtl/encode_deframer.sv | 119 +++++++++++
 tb/tb_encode_deframer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/encode_deframer.sv
// encode_deframer: packs the comparator encoder's bit stream into words (first bit in MSB),
// counts the ones per word and buffers completed words in a small first-word-fall-through
// FIFO that drains through a valid/ready handshake.
module encode_deframer #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 4,
    localparam int CNT_W  = $clog2(WORD_W + 1),
    localparam int POS_W  = $clog2(WORD_W),
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int FCNT_W = $clog2(DEPTH + 1)
) (
    input  logic              CLK100MHZ,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              flush,
    output logic [WORD_W-1:0] word_out,
    output logic [CNT_W-1:0]  ones_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic [FCNT_W-1:0] fifo_count,
    output logic [POS_W-1:0]  bit_pos,
    output logic              overflow
);

    localparam logic [POS_W-1:0]  LAST_POS = POS_W'(WORD_W - 1);
    localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(DEPTH);

    logic [WORD_W-1:0] shreg;
    logic [CNT_W-1:0]  acc;

    logic [WORD_W-1:0] mem_word [DEPTH];
    logic [CNT_W-1:0]  mem_ones [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic [WORD_W-1:0] next_word;
    logic [CNT_W-1:0]  next_ones;
    logic              push;
    logic              pop;
    logic              full;
    logic              push_ok;

    // Word completion and FIFO handshake decode.
    always_comb begin
        next_word = {shreg[WORD_W-2:0], bit_in};
        next_ones = acc + CNT_W'(bit_in);
        push      = bit_valid && !flush && (bit_pos == LAST_POS);
        word_valid = (fifo_count != '0);
        pop       = word_valid && word_ready;
        full      = (fifo_count == FULL_CNT);
        // A pop on the same edge frees the slot a full FIFO needs for the push.
        push_ok   = push && (!full || pop);
    end

    // Bit assembly: shift in sampled bits, clear on flush or when a word completes.
    always_ff @(posedge CLK100MHZ) begin
        if (reset || flush) begin
            shreg   <= '0;
            acc     <= '0;
            bit_pos <= '0;
        end else if (bit_valid) begin
            if (bit_pos == LAST_POS) begin
                shreg   <= '0;
                acc     <= '0;
                bit_pos <= '0;
            end else begin
                shreg   <= next_word;
                acc     <= next_ones;
                bit_pos <= bit_pos + 1'b1;
            end
        end
    end

    // FIFO storage; zeroed on reset so an empty FIFO reads 0.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_word[i] <= '0;
                mem_ones[i] <= '0;
            end
        end else if (push_ok) begin
            mem_word[wr_ptr] <= next_word;
            mem_ones[wr_ptr] <= next_ones;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!push_ok && pop) begin
                fifo_count <= fifo_count - 1'b1;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Fall-through head of FIFO.
    always_comb begin
        word_out = mem_word[rd_ptr];
        ones_out = mem_ones[rd_ptr];
    end

endmodule

// File: tb/tb_encode_deframer.sv
// Directed testbench for encode_deframer with hand-computed expected values.
module tb_encode_deframer;

    logic       CLK100MHZ = 1'b0;
    logic       reset = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] word_out;
    logic [3:0] ones_out;
    logic       word_valid;
    logic       word_ready = 1'b0;
    logic [2:0] fifo_count;
    logic [2:0] bit_pos;
    logic       overflow;

    int n_checks = 0;
    int n_bad = 0;

    encode_deframer #(.WORD_W(8), .DEPTH(4)) dut (
        .CLK100MHZ (CLK100MHZ),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .flush     (flush),
        .word_out  (word_out),
        .ones_out  (ones_out),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .fifo_count(fifo_count),
        .bit_pos   (bit_pos),
        .overflow  (overflow)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; sample point is 1 time unit after it.
    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in = b;
        tick();
        bit_valid = 1'b0;
        bit_in = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [7:0] pat;
    logic [7:0] exp_words [4];

    initial begin
        pat = 8'b1011_0001;
        #1;
        do_reset();
        check_eq("rst_valid", 32'(word_valid), 32'd0);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_pos", 32'(bit_pos), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_word", 32'(word_out), 32'd0);
        check_eq("rst_ones", 32'(ones_out), 32'd0);

        // 1: back-to-back bits
        for (int i = 7; i >= 0; i--) begin
            send_bit(pat[i]);
            if (i == 5) check_eq("t1_pos3", 32'(bit_pos), 32'd3);
            if (i == 1) check_eq("t1_novalid", 32'(word_valid), 32'd0);
        end
        check_eq("t1_valid", 32'(word_valid), 32'd1);
        check_eq("t1_word", 32'(word_out), 32'hB1);
        check_eq("t1_ones", 32'(ones_out), 32'd4);
        check_eq("t1_count", 32'(fifo_count), 32'd1);
        check_eq("t1_pos", 32'(bit_pos), 32'd0);
        tick();
        check_eq("t1_stable", 32'(word_out), 32'hB1);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check_eq("t1_drained", 32'(word_valid), 32'd0);

        // 2: gaps of 0..3 idle cycles between bits
        for (int i = 0; i < 8; i++) begin
            send_bit(pat[7-i]);
            for (int g = 0; g < (i % 4); g++) begin
                tick();
                check_eq("t2_hold", 32'(bit_pos), 32'((i + 1) % 8));
            end
        end
        check_eq("t2_word", 32'(word_out), 32'hB1);
        check_eq("t2_ones", 32'(ones_out), 32'd4);
        check_eq("t2_count", 32'(fifo_count), 32'd1);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;

        // 3: partial word flushed (a bit on the flush edge is discarded)
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        check_eq("t3_pos3", 32'(bit_pos), 32'd3);
        flush = 1'b1;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        tick();
        flush = 1'b0;
        bit_valid = 1'b0;
        check_eq("t3_pos0", 32'(bit_pos), 32'd0);
        check_eq("t3_empty", 32'(word_valid), 32'd0);
        send_word(8'hFF);
        check_eq("t3_word", 32'(word_out), 32'hFF);
        check_eq("t3_ones", 32'(ones_out), 32'd8);
        check_eq("t3_count", 32'(fifo_count), 32'd1);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check_eq("t3_drained", 32'(word_valid), 32'd0);

        // 4: overflow on the 5th word, then drain in order
        for (int k = 1; k <= 5; k++) send_word(8'(k));
        check_eq("t4_count", 32'(fifo_count), 32'd4);
        check_eq("t4_ovf", 32'(overflow), 32'd1);
        check_eq("t4_head", 32'(word_out), 32'h01);
        word_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check_eq("t4_pop", 32'(word_out), 32'(k));
            check_eq("t4_pop_ones", 32'(ones_out), 32'($countones(k)));
            tick();
        end
        word_ready = 1'b0;
        check_eq("t4_empty", 32'(word_valid), 32'd0);
        check_eq("t4_ovf_sticky", 32'(overflow), 32'd1);
        tick();
        check_eq("t4_count0", 32'(fifo_count), 32'd0);

        // 5: push into a full FIFO on the same edge as a pop
        do_reset();
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        send_word(8'h44);
        check_eq("t5_full", 32'(fifo_count), 32'd4);
        for (int i = 7; i >= 1; i--) send_bit(pat[i] ^ 1'b1);
        word_ready = 1'b1;
        send_bit(pat[0] ^ 1'b1);
        word_ready = 1'b0;
        check_eq("t5_ovf", 32'(overflow), 32'd0);
        check_eq("t5_count", 32'(fifo_count), 32'd4);
        check_eq("t5_head", 32'(word_out), 32'h22);
        exp_words[0] = 8'h22;
        exp_words[1] = 8'h33;
        exp_words[2] = 8'h44;
        exp_words[3] = 8'h4E;
        word_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_eq("t5_pop", 32'(word_out), 32'(exp_words[k]));
            tick();
        end
        word_ready = 1'b0;
        check_eq("t5_empty", 32'(word_valid), 32'd0);

        // 6: reset mid-word and mid-drain, with a bit on the reset edge
        send_word(8'hAA);
        send_word(8'hBB);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check_eq("t6_pos5", 32'(bit_pos), 32'd5);
        check_eq("t6_count2", 32'(fifo_count), 32'd2);
        reset = 1'b1;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        bit_valid = 1'b0;
        bit_in = 1'b0;
        flush = 1'b0;
        check_eq("t6_pos", 32'(bit_pos), 32'd0);
        check_eq("t6_count", 32'(fifo_count), 32'd0);
        check_eq("t6_valid", 32'(word_valid), 32'd0);
        check_eq("t6_ovf", 32'(overflow), 32'd0);
        send_word(8'h80);
        check_eq("t6_word", 32'(word_out), 32'h80);
        check_eq("t6_ones", 32'(ones_out), 32'd1);
        check_eq("t6_count1", 32'(fifo_count), 32'd1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
